// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [AW-1:0]   rf_addr_t;
  typedef logic [XLEN-1:0] rf_word_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_word_t data;
  } wb_entry_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Youngest-match search over the queued writeback entries.
// Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1).
// Built only when RF_WB_FWD_EN is defined.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [AW-1:0]         addr,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  // Later (younger) matches override earlier ones; x0 never matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (addr != '0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid[i] && (entries[i].addr == addr)) begin
          hit  = 1'b1;
          data = entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO in front of the register file's single write port.
// Optional feature macro RF_WB_FWD_EN: when defined, queued values are
// forwarded to the decode read ports; otherwise the fwd outputs are tied to 0
// and the core must stall while count != 0.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   rf_grant,
  output logic                   rf_wr_en,
  output logic [AW-1:0]          rf_write_addr,
  output logic [XLEN-1:0]        rf_write_data,
  input  logic [AW-1:0]          fwd_rs1_addr,
  input  logic [AW-1:0]          fwd_rs2_addr,
  output logic                   fwd_rs1_hit,
  output logic [XLEN-1:0]        fwd_rs1_data,
  output logic                   fwd_rs2_hit,
  output logic [XLEN-1:0]        fwd_rs2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q;
  logic            push, pop, empty;
  wb_entry_t       head;

  assign empty    = (count_q == '0);
  assign wb_ready = (count_q < DEPTH_C);
  assign rf_wr_en = !empty && rf_grant;
  assign pop      = rf_wr_en;
  // x0 writes complete the handshake but are dropped here.
  assign push     = wb_valid && wb_ready && (wb_addr != '0);
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Head entry drives the write port; zeros when nothing is queued.
  always_comb begin
    rf_write_addr = '0;
    rf_write_data = '0;
    if (!empty) begin
      rf_write_addr = head.addr;
      rf_write_data = head.data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Entry storage; validity is implied by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: wb_addr, data: wb_data};
    end
  end

`ifdef RF_WB_FWD_EN
  wb_entry_t [DEPTH-1:0] age_ent;
  logic [DEPTH-1:0]      age_vld;

  // Rotate storage so index 0 is the oldest entry (the head).
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_ent[i] = mem_q[rd_ptr_q + PW'(i)];
      age_vld[i] = ((PW+1)'(i) < count_q);
    end
  end

  rf_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_rs1 (
    .entries (age_ent),
    .valid   (age_vld),
    .addr    (fwd_rs1_addr),
    .hit     (fwd_rs1_hit),
    .data    (fwd_rs1_data)
  );

  rf_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_rs2 (
    .entries (age_ent),
    .valid   (age_vld),
    .addr    (fwd_rs2_addr),
    .hit     (fwd_rs2_hit),
    .data    (fwd_rs2_data)
  );
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit     = 1'b0;
  assign fwd_rs1_data    = '0;
  assign fwd_rs2_hit     = 1'b0;
  assign fwd_rs2_data    = '0;
`endif

  // Occupancy can never exceed the storage.
  a_count_bound : assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_grant;
  logic        rf_wr_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic [2:0]  count;

  rf_writeback_queue #(
    .DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .rf_grant      (rf_grant),
    .rf_wr_en      (rf_wr_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .fwd_rs1_addr  (fwd_rs1_addr),
    .fwd_rs2_addr  (fwd_rs2_addr),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs1_data  (fwd_rs1_data),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_rs2_data  (fwd_rs2_data),
    .count         (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] dut_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      foreach (mq[i]) begin
        if (mq[i].a == a) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
    end
`ifndef RF_WB_FWD_EN
    h = 1'b0;
    d = '0;
`endif
  endfunction

  // Reference model update at the active edge.
  always @(posedge clk) begin
    int   cnt;
    ent_t e;
    cnt = mq.size();
    if (reset) begin
      mq.delete();
    end else begin
      if (cnt != 0 && rf_grant) void'(mq.pop_front());
      if (wb_valid && cnt < 4 && wb_addr != 0) begin
        e.a = wb_addr;
        e.d = wb_data;
        mq.push_back(e);
      end
    end
  end

  // Bench-side register file fed from the DUT's write port.
  always @(posedge clk) begin
    if (rf_wr_en) begin
      dut_rf[rf_write_addr] <= rf_write_data;
      n_writes <= n_writes + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int          cnt;
    logic        h1, h2;
    logic [31:0] d1, d2;
    if (checking) begin
      cnt = mq.size();
      fwd_model(fwd_rs1_addr, h1, d1);
      fwd_model(fwd_rs2_addr, h2, d2);
      chk("count", 32'(count), 32'(cnt));
      chk("wb_ready", 32'(wb_ready), 32'(cnt < 4));
      chk("rf_wr_en", 32'(rf_wr_en), 32'(cnt != 0 && rf_grant));
      chk("rf_write_addr", 32'(rf_write_addr), (cnt != 0) ? 32'(mq[0].a) : 32'd0);
      chk("rf_write_data", rf_write_data, (cnt != 0) ? mq[0].d : 32'd0);
      chk("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(h1));
      chk("fwd_rs1_data", fwd_rs1_data, d1);
      chk("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(h2));
      chk("fwd_rs2_data", fwd_rs2_data, d2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    cyc();
    wb_valid = 1'b0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    reset        = 1'b1;
    wb_valid     = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    rf_grant     = 1'b0;
    fwd_rs1_addr = '0;
    fwd_rs2_addr = '0;
    cyc();
    checking = 1'b1;
    cyc();
    reset = 1'b0;

    // Reset state and idle.
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_waddr", 32'(rf_write_addr), 32'd0);
    repeat (3) cyc();
    chk("idle_writes", 32'(n_writes), 32'd0);

    // Single write: -245 to x10, visible on the port one cycle after accept.
    rf_grant = 1'b1;
    push(5'd10, -32'sd245);
    chk("t2_wr_en", 32'(rf_wr_en), 32'd1);
    chk("t2_addr", 32'(rf_write_addr), 32'd10);
    chk("t2_data", rf_write_data, 32'hFFFF_FF0B);
    cyc();
    chk("t2_rf_x10", dut_rf[10], 32'hFFFF_FF0B);
    chk("t2_count", 32'(count), 32'd0);

    // Fill to full with the port stalled, hold a 5th, then drain in order.
    rf_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i));
    chk("t3_ready", 32'(wb_ready), 32'd0);
    chk("t3_count", 32'(count), 32'd4);
    wb_valid = 1'b1;
    wb_addr  = 5'd6;
    wb_data  = 32'd66;
    repeat (2) cyc();
    chk("t3_held", 32'(count), 32'd4);
    wb_valid = 1'b0;
    rf_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain_addr", 32'(rf_write_addr), 32'(i));
      chk("t3_drain_data", rf_write_data, 32'(i));
      cyc();
    end
    chk("t3_empty", 32'(count), 32'd0);
    chk("t3_rf_x4", dut_rf[4], 32'd4);

    // Forwarding: youngest match for x5, x0 never hits.
    rf_grant     = 1'b0;
    fwd_rs1_addr = 5'd5;
    fwd_rs2_addr = 5'd0;
    push(5'd5, 32'd7);
    push(5'd5, 32'd9);
    push(5'd3, 32'd11);
`ifdef RF_WB_FWD_EN
    chk("t4_rs1_hit", 32'(fwd_rs1_hit), 32'd1);
    chk("t4_rs1_data", fwd_rs1_data, 32'd9);
`else
    chk("t4_rs1_hit", 32'(fwd_rs1_hit), 32'd0);
    chk("t4_rs1_data", fwd_rs1_data, 32'd0);
`endif
    chk("t4_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    rf_grant = 1'b1;
    for (int i = 0; i < 10 && count != 0; i++) cyc();
    chk("t4_drained", 32'(count), 32'd0);
    chk("t4_rf_x5", dut_rf[5], 32'd9);

    // x0 writeback: handshake completes, nothing queued or written.
    w0 = n_writes;
    chk("t5_ready", 32'(wb_ready), 32'd1);
    push(5'd0, 32'hDEAD);
    chk("t5_count", 32'(count), 32'd0);
    repeat (3) cyc();
    chk("t5_no_write", 32'(n_writes), 32'(w0));

    // Reset mid-operation discards queued writes.
    rf_grant = 1'b0;
    push(5'd7, 32'd70);
    push(5'd8, 32'd80);
    push(5'd9, 32'd90);
    chk("t6_count", 32'(count), 32'd3);
    w0    = n_writes;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_rst_count", 32'(count), 32'd0);
    rf_grant = 1'b1;
    repeat (4) cyc();
    chk("t6_no_write", 32'(n_writes), 32'(w0));
    chk("t6_rf_x7", dut_rf[7], 32'd0);

    // Mixed stream with simultaneous accept/pop, checked by the model.
    fwd_rs1_addr = 5'd12;
    fwd_rs2_addr = 5'd13;
    for (int i = 0; i < 40; i++) begin
      wb_valid = (i % 3) != 2;
      wb_addr  = 5'(12 + (i % 3));
      wb_data  = 32'(i * 17 + 1);
      rf_grant = (i % 5) < 2;
      cyc();
    end
    wb_valid = 1'b0;
    rf_grant = 1'b1;
    repeat (6) cyc();
    chk("t7_empty", 32'(count), 32'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
